bcd_7seg_scan: RTL
==================

BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, giving the clock cycles each digit is lit per scan slot (legal range 2..65535).
REQ-002 SHALL have parameter GAP_CYC, default 16, giving the all-off clock cycles between digit slots, for anti-ghosting (legal range 1..255).
REQ-003 SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state changes on the rising edge of clk.
REQ-004 Ports:
- clk, input, 1 bit: system clock.
- rst, input, 1 bit: synchronous active-high reset.
- bcd_in, input, 6 bits: converter output; [5:4] are tens 0-3, [3:0] are ones 0-9; 6'b111111 means invalid.
- load, input, 1 bit: capture bcd_in on this edge.
- upd_ack, output, 1 bit: one-cycle pulse when a new value becomes the displayed value.
- err, output, 1 bit: the displayed value is invalid.
- seg_n, output, 7 bits: active-low segments; [0]=a through [6]=g.
- an_n, output, 2 bits: active-low digit enables; [0]=ones, [1]=tens.

Function
REQ-005 SHALL implement states IDLE, ONES, GAP1, TENS and GAP2, with a cycle counter scan_cnt of at least 16 bits.
REQ-006 IDLE SHALL drive an_n=2'b11 and seg_n=7'h7F, and SHALL remain in IDLE until the first load.
REQ-007 On load in IDLE, disp SHALL take bcd_in and the next state SHALL be ONES with scan_cnt=0; upd_ack SHALL pulse on that edge.
REQ-008 Each of ONES and TENS SHALL last exactly SCAN_DIV cycles, and each of GAP1 and GAP2 SHALL last exactly GAP_CYC cycles.
REQ-009 The state order SHALL be ONES->GAP1->TENS->GAP2->ONES, and scan_cnt SHALL clear on every state change.
REQ-010 Outside IDLE, load SHALL write bcd_in into a pending register and set pend_v; a later load before transfer SHALL overwrite the pending register (last write wins).
REQ-011 On the GAP2->ONES transition with pend_v=1, disp SHALL take the pending value, pend_v SHALL clear, and upd_ack SHALL pulse; disp SHALL NOT change at any other time outside IDLE.
REQ-012 If load is high on the GAP2->ONES edge itself, disp SHALL take bcd_in directly (bypass), pend_v SHALL clear, and upd_ack SHALL pulse.
REQ-013 ONES SHALL drive an_n=2'b10, TENS SHALL drive an_n=2'b01, and GAP1 and GAP2 SHALL drive an_n=2'b11 with seg_n=7'h7F.
REQ-014 Segment patterns, active-high gfedcba, SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40; seg_n SHALL be the bitwise inverse.
REQ-015 disp SHALL be invalid when disp[3:0]>9, which includes 6'b111111; when invalid, err SHALL be 1 and both digit slots SHALL show a dash.
REQ-016 Leading-zero blanking: when disp is valid and disp[5:4]=0, the TENS slot SHALL drive an_n=2'b11.
REQ-017 seg_n, an_n and err SHALL depend only on state and disp registers, with no combinational path from bcd_in or load.
REQ-018 upd_ack SHALL be registered and SHALL never be high for two consecutive cycles.

Reset
REQ-019 rst SHALL force, on the next edge, state=IDLE, scan_cnt=0, disp=0, pending=0, pend_v=0, upd_ack=0 and err=0, giving outputs an_n=2'b11 and seg_n=7'h7F.
REQ-020 rst SHALL take priority over load and over any transition, including reset asserted mid-slot; load in the same cycle as rst SHALL be discarded.

Verification (SCAN_DIV=4, GAP_CYC=1; cycle n = edge n)
REQ-021 rst, then load with bcd_in=6'b100101 at cycle 0 -> upd_ack=1 in cycle 1.
- Cycles 1-4: an_n=10, seg_n=7'h12.
- Cycle 5: an_n=11.
- Cycles 6-9: an_n=01, seg_n=7'h24.
- Cycle 10: an_n=11.
- Cycle 11: ONES again.
REQ-022 Displaying 25, load 6'b000111 during TENS -> display stays 25 until GAP2 ends, then the ONES slot shows 7'h78 with upd_ack=1, and the TENS slot shows an_n=11 (leading zero blanked).
REQ-023 Two loads in one scan (values 12 then 33) -> only 33 is displayed, and exactly one upd_ack pulse occurs.
REQ-024 load 6'b111111, and separately load 6'b001010 -> err=1 and both slots show seg_n=7'h3F.
REQ-025 rst asserted mid-TENS together with load=1 -> IDLE next cycle, all outputs at reset values, and the display stays blank until a new load.
REQ-026 load coincident with the GAP2->ONES edge -> the new value is displayed in that same ONES slot.

Source files
------------

// File: rtl/bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : bcd_7seg_scan
// Purpose  : Two-digit multiplexed 7-segment driver for a 0-39 BCD value.
//            Scans ONES -> GAP1 -> TENS -> GAP2 and shows a dash on invalid
//            data. New values are held pending and committed only at scan
//            wrap so that a digit never changes mid-scan.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_7seg_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int GAP_CYC  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] bcd_in,
    input  logic       load,
    output logic       upd_ack,
    output logic       err,
    output logic [6:0] seg_n,
    output logic [1:0] an_n
);

    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_ONES   = 3'd1;
    localparam logic [2:0]  c_ST_GAP1   = 3'd2;
    localparam logic [2:0]  c_ST_TENS   = 3'd3;
    localparam logic [2:0]  c_ST_GAP2   = 3'd4;

    localparam logic [15:0] c_SLOT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] c_GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [6:0]  c_DASH      = 7'h40;
    localparam logic [6:0]  c_BLANK_N   = 7'h7F;

    logic [2:0]  r_state;
    logic [15:0] r_scan_cnt;
    logic [5:0]  r_disp;
    logic [5:0]  r_pend;
    logic        r_pend_v;
    logic        r_upd_ack;

    logic        w_slot_last;
    logic        w_gap_last;
    logic        w_wrap;
    logic        w_valid;
    logic [6:0]  w_ones_pat;
    logic [6:0]  w_tens_pat;

    // Active-high gfedcba pattern for a decimal digit.
    function automatic logic [6:0] f_seg(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = c_DASH;
        endcase
        return pat;
    endfunction

    assign w_slot_last = (r_scan_cnt == c_SLOT_LAST);
    assign w_gap_last  = (r_scan_cnt == c_GAP_LAST);
    assign w_wrap      = (r_state == c_ST_GAP2) && w_gap_last;
    assign w_valid     = (r_disp[3:0] <= 4'd9);
    assign w_ones_pat  = w_valid ? f_seg(r_disp[3:0]) : c_DASH;
    assign w_tens_pat  = w_valid ? f_seg({2'b00, r_disp[5:4]}) : c_DASH;
    assign upd_ack     = r_upd_ack;
    assign err         = ~w_valid;

    // Scan sequencing, display commit at scan wrap and pending capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_scan_cnt <= 16'd0;
            r_disp     <= 6'd0;
            r_pend     <= 6'd0;
            r_pend_v   <= 1'b0;
            r_upd_ack  <= 1'b0;
        end else begin
            r_upd_ack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (load) begin
                        r_disp     <= bcd_in;
                        r_state    <= c_ST_ONES;
                        r_scan_cnt <= 16'd0;
                        r_upd_ack  <= 1'b1;
                    end
                end
                c_ST_ONES: begin
                    if (w_slot_last) begin
                        r_state    <= c_ST_GAP1;
                        r_scan_cnt <= 16'd0;
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 16'd1;
                    end
                end
                c_ST_GAP1: begin
                    if (w_gap_last) begin
                        r_state    <= c_ST_TENS;
                        r_scan_cnt <= 16'd0;
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 16'd1;
                    end
                end
                c_ST_TENS: begin
                    if (w_slot_last) begin
                        r_state    <= c_ST_GAP2;
                        r_scan_cnt <= 16'd0;
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 16'd1;
                    end
                end
                c_ST_GAP2: begin
                    if (w_gap_last) begin
                        r_state    <= c_ST_ONES;
                        r_scan_cnt <= 16'd0;
                        // A load on the wrap edge itself bypasses the pending slot.
                        if (load) begin
                            r_disp    <= bcd_in;
                            r_pend_v  <= 1'b0;
                            r_upd_ack <= 1'b1;
                        end else if (r_pend_v) begin
                            r_disp    <= r_pend;
                            r_pend_v  <= 1'b0;
                            r_upd_ack <= 1'b1;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_scan_cnt <= 16'd0;
                end
            endcase
            // While scanning, loads land in the pending slot; last write wins.
            if (load && (r_state != c_ST_IDLE) && !w_wrap) begin
                r_pend   <= bcd_in;
                r_pend_v <= 1'b1;
            end
        end
    end

    // Digit enables and segments decoded purely from state and displayed value.
    always_comb begin
        an_n  = 2'b11;
        seg_n = c_BLANK_N;
        case (r_state)
            c_ST_ONES: begin
                an_n  = 2'b10;
                seg_n = ~w_ones_pat;
            end
            c_ST_TENS: begin
                // Leading zero stays dark; an invalid value still shows its dash.
                if (!w_valid || (r_disp[5:4] != 2'd0)) begin
                    an_n  = 2'b01;
                    seg_n = ~w_tens_pat;
                end
            end
            default: begin
                an_n  = 2'b11;
                seg_n = c_BLANK_N;
            end
        endcase
    end

endmodule
`default_nettype wire
